// File: rtl/mips32_dmem_arb.sv
// Two-master data-memory arbiter for the MIPS32 core: CPU MEM stage vs host
// debug/loader port, with registered grants, starvation guard and read routing.
module mips32_dmem_arb #(
   parameter int AW       = 9,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk_1,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   input  logic          cpu_halted,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, GNT_C, GNT_H} state_t;

   localparam logic [3:0] WMAX = 4'(MAX_WAIT);

   state_t          state_q, state_d;
   logic [3:0]      wait_cnt_q, wait_cnt_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic            rd_vld_q, rd_vld_d;
   logic            rd_tag_q, rd_tag_d;
   logic            cpu_elig, host_elig, host_pri;

   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_vld_q    <= 1'b0;
         rd_tag_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_vld_q    <= rd_vld_d;
         rd_tag_q    <= rd_tag_d;
      end
   end

   always_comb begin
      state_d     = IDLE;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wait_cnt_d  = wait_cnt_q;
      rd_vld_d    = 1'b0;
      rd_tag_d    = rd_tag_q;

      // a requester just granted still shows its old request this cycle
      cpu_elig  = cpu_req && (state_q != GNT_C);
      host_elig = host_req && (state_q != GNT_H);
      host_pri  = cpu_halted || (wait_cnt_q == WMAX);

      if (host_elig && (host_pri || !cpu_elig)) begin
         state_d     = GNT_H;
         mem_en_d    = 1'b1;
         mem_we_d    = host_we;
         mem_addr_d  = host_addr;
         mem_wdata_d = host_wdata;
      end else if (cpu_elig) begin
         state_d     = GNT_C;
         mem_en_d    = 1'b1;
         mem_we_d    = cpu_we;
         mem_addr_d  = cpu_addr;
         mem_wdata_d = cpu_wdata;
      end

      if (state_q != IDLE && !mem_we_q) begin
         rd_vld_d = 1'b1;
         rd_tag_d = (state_q == GNT_H);
      end

      if (state_q == GNT_H)
         wait_cnt_d = '0;
      else if (host_req && wait_cnt_q < WMAX)
         wait_cnt_d = wait_cnt_q + 4'd1;
   end

   assign cpu_gnt     = (state_q == GNT_C);
   assign host_gnt    = (state_q == GNT_H);
   assign mem_en      = mem_en_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign cpu_rvalid  = rd_vld_q && !rd_tag_q;
   assign host_rvalid = rd_vld_q && rd_tag_q;
   assign cpu_rdata   = cpu_rvalid ? mem_rdata : '0;
   assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mips32_dmem_arb.md
MIPS32_DMEM_ARB -- requirements
Module: mips32_dmem_arb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): AW, 9, word-address width; DW, 32, data width; MAX_WAIT, 4, host starvation limit in cycles (range 1..15).
REQ-002 The block SHALL have these ports (name direction width meaning), clock and reset first:
- clk_1  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU MEM-stage access request
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  AW  word address
- cpu_wdata  in  DW  store data
- cpu_gnt  out  1  CPU access accepted
- cpu_rvalid  out  1  CPU load data valid
- cpu_rdata  out  DW  CPU load data
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  host (debug/loader) request, same meaning as CPU
- host_gnt, host_rvalid, host_rdata  out  1/1/DW  host grant, load-data valid, load data
- cpu_halted  in  1  processor halted flag
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after a read strobe

Function
REQ-003 Requesters SHALL hold req, we, addr and wdata stable from assertion until the cycle gnt is high; the requester drops or changes the request in the cycle after gnt.
REQ-004 The FSM SHALL have three states: IDLE, GNT_C and GNT_H; state, grant and mem_* outputs are all registered.
REQ-005 In cycle N the arbiter SHALL sample the requests, pick a winner, and enter GNT_C or GNT_H at edge N+1; with no eligible request it SHALL go to, or stay in, IDLE.
REQ-006 In GNT_x, x_gnt SHALL be 1 for exactly one cycle, and mem_en=1, mem_we, mem_addr and mem_wdata SHALL carry that requester's latched values.
REQ-007 In IDLE, mem_en, mem_we, cpu_gnt and host_gnt SHALL be 0.
REQ-008 In GNT_x, the same requester's req SHALL be ignored for the next arbitration (it is the stale held request); the other requester is eligible, so alternating back-to-back grants are allowed.
REQ-009 Default priority SHALL be: CPU wins when both are eligible.
REQ-010 Host priority SHALL override the CPU when cpu_halted=1 or wait_cnt==MAX_WAIT.
REQ-011 wait_cnt (4-bit) SHALL increment each cycle host_req=1 and the host is not granted, saturating at MAX_WAIT; it SHALL clear to 0 on host_gnt.
REQ-012 For a load granted in cycle G, x_rvalid SHALL be 1 in cycle G+1 only, with x_rdata=mem_rdata.
REQ-013 A registered tag SHALL route read data to the requester that issued the load.
REQ-014 When x_rvalid=0, x_rdata SHALL be 0.
REQ-015 Stores SHALL produce no rvalid.
REQ-016 Load-to-use latency SHALL be 2 cycles from the request-sample cycle; peak throughput SHALL be one access per cycle when both requesters alternate, and one per 2 cycles for a single requester.
REQ-017 Address and data SHALL pass through unmodified; there is no range check (2^AW words are fully mapped).
REQ-018 When a host store and a CPU load are granted on consecutive cycles to the same address, memory order SHALL equal grant order; the arbiter does no forwarding.

Reset
REQ-019 While rst=0, state SHALL be IDLE and wait_cnt, read tag, all gnt, all rvalid, all rdata, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-020 Reset asserted mid-access SHALL discard the access: a pending rvalid is not produced after reset release.
REQ-021 The first arbitration SHALL occur on the first clk_1 edge after rst deasserts.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- CPU-only load: cpu_req=1, cpu_we=0, cpu_addr=9'h010, memory[0x10]=32'hDEADBEEF -> cpu_gnt one cycle later, mem_addr=0x010, cpu_rvalid the following cycle with cpu_rdata=32'hDEADBEEF, no host outputs.
- Simultaneous requests, cpu_halted=0: CPU store to 0x020 and host load from 0x030 -> CPU granted first, host granted the next cycle, host_rvalid one cycle after that.
- Starvation: cpu_req toggling continuously with host_req=1 and MAX_WAIT=4 -> host_gnt within 5 cycles of the host request, then wait_cnt=0.
- cpu_halted=1 with both requesting -> host wins every contested arbitration.
- Reset while in GNT_H with a load in flight -> no host_rvalid afterward; all outputs 0 during reset.
- Back-to-back single requester: cpu_req held across 3 loads -> grants on alternate cycles, each rvalid paired with the correct address data.
